// File: rtl/tile_buffer_pkg.sv
// -----------------------------------------------------------------------------
// tile_buffer_pkg
// Shared definitions for the text-mode tile buffer: default geometry and fill
// value, the fill-engine state encoding and the row-wrap helper used by the
// logical-to-physical row mapping.
// -----------------------------------------------------------------------------
package tile_buffer_pkg;

    localparam int DEF_COLS   = 80;
    localparam int DEF_ROWS   = 30;
    localparam int DEF_DATA_W = 7;
    localparam int DEF_FILL   = 0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CLEAR  = 2'd1,
        SCROLL = 2'd2
    } state_t;

    // Both operands are already below rows, so a single conditional
    // subtract is enough to wrap the sum back into range (no divider).
    function automatic int wrapRow(input int row, input int rows);
        return (row >= rows) ? row - rows : row;
    endfunction

endpackage

// File: rtl/tile_buffer_if.sv
// -----------------------------------------------------------------------------
// tile_buffer_if
// Bus between the character writer / glyph lookup and the tile buffer.
//   wr_en_i, col_w_i, row_w_i, din_i : write port
//   col_r_i, row_r_i, dout_o         : registered read port
//   clr_i, scroll_i                  : single-cycle fill requests
//   busy_o, done_o                   : fill engine status
// The master modport belongs to the client, the slave modport to the buffer.
// -----------------------------------------------------------------------------
interface tile_buffer_if #(
    parameter int COL_W  = 7,
    parameter int ROW_W  = 5,
    parameter int DATA_W = 7
);
    logic              wr_en_i;
    logic [COL_W-1:0]  col_w_i;
    logic [ROW_W-1:0]  row_w_i;
    logic [DATA_W-1:0] din_i;
    logic [COL_W-1:0]  col_r_i;
    logic [ROW_W-1:0]  row_r_i;
    logic [DATA_W-1:0] dout_o;
    logic              clr_i;
    logic              scroll_i;
    logic              busy_o;
    logic              done_o;

    modport master (
        output wr_en_i, col_w_i, row_w_i, din_i, col_r_i, row_r_i, clr_i, scroll_i,
        input  dout_o, busy_o, done_o
    );

    modport slave (
        input  wr_en_i, col_w_i, row_w_i, din_i, col_r_i, row_r_i, clr_i, scroll_i,
        output dout_o, busy_o, done_o
    );
endinterface

// File: rtl/tile_buffer_ram.sv
// -----------------------------------------------------------------------------
// tile_buffer_ram
// Simple dual-port RAM, one write port and one registered read port.
//   i_clk   : clock
//   i_we    : write enable
//   i_waddr : write address
//   i_wdata : write data
//   i_raddr : read address, sampled on the clock edge
//   o_rdata : read data, valid after the edge that sampled i_raddr
// The array has no reset so it maps onto block RAM. A read and write to the
// same address on the same edge returns the old contents.
// -----------------------------------------------------------------------------
module tile_buffer_ram #(
    parameter int DEPTH  = 2400,
    parameter int WIDTH  = 7,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0]  i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [WIDTH-1:0]  o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    // Write and read in the same block so the read sees pre-write contents.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/tile_buffer.sv
// -----------------------------------------------------------------------------
// tile_buffer
// Parametrised text-mode tile buffer: one DATA_W code per tile, a write port,
// a registered read port, a clear engine, and vertical scroll via a circular
// row base.
//   clk_i  : system clock
//   rst_ni : asynchronous active-low reset
//   bus    : tile_buffer_if slave (write/read ports, clr/scroll, busy/done)
// -----------------------------------------------------------------------------
module tile_buffer
    import tile_buffer_pkg::*;
#(
    parameter int                COLS           = DEF_COLS,
    parameter int                ROWS           = DEF_ROWS,
    parameter int                DATA_W         = DEF_DATA_W,
    parameter logic [DATA_W-1:0] FILL           = DATA_W'(DEF_FILL),
    parameter int                CLEAR_ON_RESET = 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    tile_buffer_if.slave bus
);

    localparam int COL_W  = $clog2(COLS);
    localparam int ROW_W  = $clog2(ROWS);
    localparam int NCELLS = COLS * ROWS;
    localparam int ADDR_W = $clog2(NCELLS);

    state_t            r_state;
    state_t            w_nextState;
    logic [ADDR_W-1:0] r_fillCnt;
    logic [ADDR_W-1:0] w_nextFillCnt;
    logic [ROW_W-1:0]  r_base;
    logic [ROW_W-1:0]  w_nextBase;
    logic [ROW_W-1:0]  r_fillRow;
    logic [ROW_W-1:0]  w_nextFillRow;
    logic              r_done;
    logic              w_nextDone;
    logic              r_startPending;
    logic              r_rdPrimed;
    logic              r_rdValid;

    logic              w_busy;
    logic              w_wrInRange;
    logic              w_rdInRange;
    logic [ADDR_W-1:0] w_fillAddr;
    logic              w_ramWe;
    logic [ADDR_W-1:0] w_ramWAddr;
    logic [DATA_W-1:0] w_ramWData;
    logic [ADDR_W-1:0] w_ramRAddr;
    logic [DATA_W-1:0] w_ramQ;

    // Logical (row, col) to flat RAM address through the circular row base.
    function automatic logic [ADDR_W-1:0] cellAddr(
        input logic [ROW_W-1:0] row,
        input logic [COL_W-1:0] col,
        input logic [ROW_W-1:0] base
    );
        int phys;
        phys = wrapRow(int'(row) + int'(base), ROWS);
        return ADDR_W'(phys * COLS + int'(col));
    endfunction

    // Next-state logic of the fill engine. A scroll advances the base on the
    // same edge it is accepted and remembers the old base row, which becomes
    // the new bottom row and is the one that gets blanked.
    always_comb begin
        w_nextState   = r_state;
        w_nextFillCnt = r_fillCnt;
        w_nextBase    = r_base;
        w_nextFillRow = r_fillRow;
        w_nextDone    = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.clr_i || r_startPending) begin
                    w_nextState   = CLEAR;
                    w_nextFillCnt = '0;
                end else if (bus.scroll_i) begin
                    w_nextState   = SCROLL;
                    w_nextFillCnt = '0;
                    w_nextFillRow = r_base;
                    w_nextBase    = ROW_W'(wrapRow(int'(r_base) + 1, ROWS));
                end
            end
            CLEAR: begin
                if (int'(r_fillCnt) == NCELLS - 1) begin
                    w_nextState = IDLE;
                    w_nextDone  = 1'b1;
                end else begin
                    w_nextFillCnt = r_fillCnt + 1'b1;
                end
            end
            SCROLL: begin
                if (int'(r_fillCnt) == COLS - 1) begin
                    w_nextState = IDLE;
                    w_nextDone  = 1'b1;
                end else begin
                    w_nextFillCnt = r_fillCnt + 1'b1;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // State, counters and read-side flags. The auto-clear request is held
    // only until the first edge after reset release.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state        <= IDLE;
            r_fillCnt      <= '0;
            r_base         <= '0;
            r_fillRow      <= '0;
            r_done         <= 1'b0;
            r_startPending <= (CLEAR_ON_RESET != 0);
            r_rdPrimed     <= 1'b0;
            r_rdValid      <= 1'b0;
        end else begin
            r_state        <= w_nextState;
            r_fillCnt      <= w_nextFillCnt;
            r_base         <= w_nextBase;
            r_fillRow      <= w_nextFillRow;
            r_done         <= w_nextDone;
            r_startPending <= 1'b0;
            r_rdPrimed     <= 1'b1;
            r_rdValid      <= w_rdInRange;
        end
    end

    // Range checks, fill address and the write-port mux. While busy the fill
    // engine owns the write port and external writes are dropped.
    always_comb begin
        w_busy      = (r_state != IDLE);
        w_wrInRange = (int'(bus.col_w_i) < COLS) && (int'(bus.row_w_i) < ROWS);
        w_rdInRange = (int'(bus.col_r_i) < COLS) && (int'(bus.row_r_i) < ROWS);
        if (r_state == CLEAR) begin
            w_fillAddr = r_fillCnt;
        end else begin
            w_fillAddr = ADDR_W'(int'(r_fillRow) * COLS + int'(r_fillCnt));
        end
        if (w_busy) begin
            w_ramWe    = 1'b1;
            w_ramWAddr = w_fillAddr;
            w_ramWData = FILL;
        end else begin
            w_ramWe    = bus.wr_en_i && w_wrInRange;
            w_ramWAddr = w_wrInRange ? cellAddr(bus.row_w_i, bus.col_w_i, r_base) : '0;
            w_ramWData = bus.din_i;
        end
        w_ramRAddr = w_rdInRange ? cellAddr(bus.row_r_i, bus.col_r_i, r_base) : '0;
    end

    tile_buffer_ram #(
        .DEPTH (NCELLS),
        .WIDTH (DATA_W)
    ) u_ram (
        .i_clk   (clk_i),
        .i_we    (w_ramWe),
        .i_waddr (w_ramWAddr),
        .i_wdata (w_ramWData),
        .i_raddr (w_ramRAddr),
        .o_rdata (w_ramQ)
    );

    // The RAM output register has no reset, so dout is forced to zero until
    // the first read after reset has been sampled; out-of-range reads give FILL.
    assign bus.dout_o = !r_rdPrimed ? '0 : (r_rdValid ? w_ramQ : FILL);
    assign bus.busy_o = w_busy;
    assign bus.done_o = r_done;

endmodule

// File: tb/tb_tile_buffer.sv
// -----------------------------------------------------------------------------
// tb_tile_buffer
// Self-checking bench for tile_buffer at default geometry. A logical 2-D grid
// model holds what each logical tile should read as; scrolls shift its rows
// up and blank the bottom row, clears fill it.
// -----------------------------------------------------------------------------
module tb_tile_buffer;

    localparam int          COLS   = 80;
    localparam int          ROWS   = 30;
    localparam int          COL_W  = 7;
    localparam int          ROW_W  = 5;
    localparam int          DATA_W = 7;
    localparam logic [6:0]  FILL   = 7'h00;

    logic clk_i;
    logic rst_ni;

    int testsRun    = 0;
    int testsFailed = 0;
    int tbBase      = 0;

    logic [DATA_W-1:0] model [ROWS][COLS];

    tile_buffer_if #(.COL_W(COL_W), .ROW_W(ROW_W), .DATA_W(DATA_W)) bus ();

    tile_buffer #(
        .COLS           (COLS),
        .ROWS           (ROWS),
        .DATA_W         (DATA_W),
        .FILL           (FILL),
        .CLEAR_ON_RESET (1)
    ) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    // Free-running clock, period 10.
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Hard time limit so a stuck design still ends the run.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs at a falling edge and wait to the next one.
    task automatic applyStimulus(input logic wr, input int cw, input int rw, input logic [6:0] d,
                                 input int cr, input int rr, input logic clr, input logic scr);
        bus.wr_en_i  = wr;
        bus.col_w_i  = 7'(cw);
        bus.row_w_i  = 5'(rw);
        bus.din_i    = d;
        bus.col_r_i  = 7'(cr);
        bus.row_r_i  = 5'(rr);
        bus.clr_i    = clr;
        bus.scroll_i = scr;
        @(negedge clk_i);
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 0, 0, 7'h00, 0, 0, 1'b0, 1'b0);
    endtask

    function automatic logic [6:0] expRead(input int c, input int r);
        if (c < COLS && r < ROWS) return model[r][c];
        return FILL;
    endfunction

    function automatic void modelClear();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                model[r][c] = FILL;
    endfunction

    function automatic void modelScroll();
        for (int r = 0; r < ROWS - 1; r++)
            for (int c = 0; c < COLS; c++)
                model[r][c] = model[r + 1][c];
        for (int c = 0; c < COLS; c++)
            model[ROWS - 1][c] = FILL;
        tbBase = (tbBase + 1) % ROWS;
    endfunction

    task automatic writeCell(input int c, input int r, input logic [6:0] d);
        applyStimulus(1'b1, c, r, d, 0, 0, 1'b0, 1'b0);
        if (c < COLS && r < ROWS) model[r][c] = d;
    endtask

    task automatic readCell(input string tag, input int c, input int r);
        logic [6:0] e;
        e = expRead(c, r);
        applyStimulus(1'b0, 0, 0, 7'h00, c, r, 1'b0, 1'b0);
        checkOutput(tag, bus.dout_o, e);
    endtask

    // Counts busy cycles starting with the current sample and checks the
    // single done pulse that coincides with busy falling.
    task automatic runFill(input string tag, input int expLen);
        int cnt  = 0;
        bit seen = 1'b0;
        for (int i = 0; i < expLen + 20 && !seen; i++) begin
            if (bus.busy_o) cnt++;
            if (bus.done_o) begin
                seen = 1'b1;
                checkOutput({tag, "_busyAtDone"}, bus.busy_o, 0);
            end else begin
                idleCycle();
            end
        end
        checkOutput({tag, "_busyLen"}, cnt, expLen);
        checkOutput({tag, "_doneSeen"}, seen, 1);
        idleCycle();
        checkOutput({tag, "_donePulse"}, bus.done_o, 0);
    endtask

    task automatic doScroll(input string tag);
        applyStimulus(1'b0, 0, 0, 7'h00, 0, 0, 1'b0, 1'b1);
        modelScroll();
        runFill(tag, COLS);
    endtask

    // Random writes and reads, including out-of-range coordinates and
    // same-cell read/write collisions (which must return the old data).
    task automatic randomPhase(input int n);
        for (int i = 0; i < n; i++) begin
            int cw, rw, cr, rr;
            logic wr;
            logic [6:0] d, e;
            wr = 1'($urandom_range(0, 1));
            cw = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, COLS - 1)) : int'($urandom_range(0, 127));
            rw = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, ROWS - 1)) : int'($urandom_range(0, 31));
            d  = 7'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                cr = cw;
                rr = rw;
            end else begin
                cr = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, COLS - 1)) : int'($urandom_range(0, 127));
                rr = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, ROWS - 1)) : int'($urandom_range(0, 31));
            end
            e = expRead(cr, rr);
            applyStimulus(wr, cw, rw, d, cr, rr, 1'b0, 1'b0);
            checkOutput("randRead", bus.dout_o, e);
            if (wr && cw < COLS && rw < ROWS) model[rw][cw] = d;
        end
    endtask

    initial begin
        int k;
        logic [6:0] expOld29, expOld27;

        rst_ni = 1'b0;
        bus.wr_en_i = 1'b0; bus.col_w_i = '0; bus.row_w_i = '0; bus.din_i = '0;
        bus.col_r_i = '0;   bus.row_r_i = '0; bus.clr_i = 1'b0; bus.scroll_i = 1'b0;
        repeat (3) @(negedge clk_i);
        checkOutput("rstDout", bus.dout_o, 0);
        checkOutput("rstBusy", bus.busy_o, 0);
        checkOutput("rstDone", bus.done_o, 0);

        // Automatic clear after reset release.
        rst_ni = 1'b1;
        checkOutput("relBusy", bus.busy_o, 0);
        idleCycle();
        runFill("resetClear", COLS * ROWS);
        modelClear();
        readCell("clrRead00", 0, 0);
        readCell("clrRead7929", 79, 29);

        // Descending sequential writes, ascending read-back.
        k = 0;
        for (int r = ROWS - 1; r >= 0; r--)
            for (int c = COLS - 1; c >= 0; c--) begin
                k++;
                writeCell(c, r, 7'(k));
            end
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                readCell("seqRead", c, r);

        randomPhase(300);

        // Single scroll: the base moves on the cycle after the request.
        writeCell(5, 3, 7'h41);
        applyStimulus(1'b0, 0, 0, 7'h00, 0, 0, 1'b0, 1'b1);
        checkOutput("scrollBusyRise", bus.busy_o, 1);
        modelScroll();
        readCell("scrollRead52", 5, 2);
        runFill("scroll", COLS - 1);
        for (int c = 0; c < COLS; c++) readCell("scrollBottom", c, ROWS - 1);
        readCell("scrollRead52b", 5, 2);

        // Thirty-one more scrolls, base wraps around the row count.
        for (int r = 0; r < ROWS; r++) writeCell(10, r, 7'(8'h20 + r));
        doScroll("wrapScroll");
        readCell("wrapMarker", 10, 0);
        for (int i = 0; i < ROWS; i++) doScroll("wrapScroll");
        for (int r = 0; r < ROWS; r++) readCell("wrapCol10", 10, r);
        writeCell(10, 1, 7'h5A);
        writeCell(79, 29, 7'h6B);
        readCell("wrapNew", 10, 1);
        readCell("wrapBottom", 79, 29);

        // Out-of-range writes dropped, out-of-range reads give FILL.
        writeCell(0, 1, 7'h12);
        writeCell(80, 0, 7'h7F);
        writeCell(0, 30, 7'h7E);
        readCell("oorAlias01", 0, 1);
        for (int r = 0; r < ROWS; r++) readCell("oorCol0", 0, r);
        readCell("oorRead127", 127, 5);
        readCell("oorRead31", 3, 31);

        // Simultaneous clear and scroll: clear wins, base stays put.
        writeCell(0, 5, 7'h11);
        writeCell(0, 6, 7'h22);
        writeCell(79, 27, 7'h3C);
        applyStimulus(1'b0, 0, 0, 7'h00, 0, 0, 1'b1, 1'b1);
        checkOutput("clrScrBusy", bus.busy_o, 1);
        applyStimulus(1'b1, 79, 27, 7'h03, 0, 5, 1'b0, 1'b0);
        checkOutput("clrWinsRead", bus.dout_o, 7'h11);
        repeat (98) idleCycle();
        checkOutput("clrLongerThanScroll", bus.busy_o, 1);

        // Physical row p currently holds logical row (p - base); after reset
        // the base is zero so logical row p reads physical row p.
        expOld29 = model[(29 - tbBase + ROWS) % ROWS][79];
        expOld27 = model[(27 - tbBase + ROWS) % ROWS][79];

        rst_ni = 1'b0;
        #1;
        checkOutput("midRstDout", bus.dout_o, 0);
        checkOutput("midRstBusy", bus.busy_o, 0);
        checkOutput("midRstDone", bus.done_o, 0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        tbBase = 0;
        idleCycle();
        checkOutput("postRstBusy", bus.busy_o, 1);
        applyStimulus(1'b0, 0, 0, 7'h00, 79, 29, 1'b0, 1'b0);
        checkOutput("postRstOld29", bus.dout_o, expOld29);
        applyStimulus(1'b0, 0, 0, 7'h00, 79, 27, 1'b0, 1'b0);
        checkOutput("postRstOld27", bus.dout_o, expOld27);
        runFill("postRstClear", COLS * ROWS - 2);
        modelClear();
        readCell("finalRead00", 0, 0);
        readCell("finalRead7929", 79, 29);

        randomPhase(200);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
